// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle between a requester and the ALU op sequencer.
interface alu_op_sequencer_if #(parameter int WIDTH = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_use_acc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_illegal;

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_illegal
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_illegal
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one command at a time through an external combinational ALU:
// accept -> execute -> hold response until consumed; keeps an accumulator of legal results.
module alu_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [2:0]        alu_sel,
  input  logic [WIDTH-1:0]  alu_result,
  output logic [WIDTH-1:0]  acc,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_illegal_q, rsp_illegal_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_sel_q     <= 3'b000;
      illegal_q     <= 1'b0;
      rsp_data_q    <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
      acc_q         <= '0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_sel_q     <= alu_sel_d;
      illegal_q     <= illegal_d;
      rsp_data_q    <= rsp_data_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
      acc_q         <= acc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_sel_d     = alu_sel_q;
    illegal_d     = illegal_q;
    rsp_data_d    = rsp_data_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
    acc_d         = acc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          alu_a_d   = bus.cmd_use_acc ? acc_q : bus.cmd_a;
          alu_b_d   = bus.cmd_b;
          alu_sel_d = bus.cmd_sel;
          illegal_d = (bus.cmd_sel > 3'b100);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d    = illegal_q ? '0 : alu_result;
        rsp_zero_d    = illegal_q ? 1'b1 : (alu_result == '0);
        rsp_illegal_d = illegal_q;
        if (!illegal_q) acc_d = alu_result;
        state_d = RESP;
      end
      RESP: begin
        // Returning to IDLE here leaves no accept edge in the consume cycle.
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_sel         = alu_sel_q;
  assign acc             = acc_q;
  assign busy            = (state_q != IDLE);

endmodule
